// File: rtl/bcd_entry_reg.sv
// -----------------------------------------------------------------------------
// bcd_entry_reg
//
// Purpose:
//    N-digit BCD entry register for the calculator display path. Decimal keys
//    are shifted in from the right. The register also supports backspace,
//    clear and parallel load of a result value. When the register is full it
//    either refuses the new digit or scrolls, depending on FULL_MODE. Leading
//    zeros are blanked for the 7-segment drivers.
//
// Parameters:
//    DIGITS     number of BCD digits held (>=1); digit 0 is least significant
//    FULL_MODE  0 = refuse a new digit when full, 1 = scroll and drop the MSD
//
// Ports:
//    clock       in   1          system clock, rising edge
//    reset       in   1          synchronous, active-high reset
//    digit       in   4          keycode for keystrobe (0-9 numeric, 10-15 not)
//    keystrobe   in   1          one-cycle pulse: append digit
//    bksp        in   1          one-cycle pulse: delete least significant digit
//    clear       in   1          one-cycle pulse: empty the register
//    load        in   1          one-cycle pulse: replace contents by load_value
//    load_value  in   4*DIGITS   packed BCD value, digit i at [4i+3:4i]
//    bcd         out  4*DIGITS   packed BCD contents, same packing
//    count       out  CW         number of significant digits, 0..DIGITS
//    blank       out  DIGITS     blank[i]=1: display digit i dark
//    full        out  1          count == DIGITS
//    reject      out  1          one-cycle pulse: numeric digit refused
// -----------------------------------------------------------------------------
module bcd_entry_reg #(
   parameter int DIGITS    = 3,
   parameter int FULL_MODE = 0,
   localparam int CW       = $clog2(DIGITS + 1)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [3:0]            digit,
   input  logic                  keystrobe,
   input  logic                  bksp,
   input  logic                  clear,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_value,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [CW-1:0]         count,
   output logic [DIGITS-1:0]     blank,
   output logic                  full,
   output logic                  reject
);

   localparam logic [CW-1:0] MAX_COUNT = CW'(DIGITS);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [4*DIGITS-1:0] r_bcd;
   logic [CW-1:0]       r_count;
   logic                r_reject;

   logic [4*DIGITS-1:0] w_bcd_next;
   logic [CW-1:0]       w_count_next;
   logic                w_reject_next;

   // Register contents shifted one digit left (new key enters at digit 0)
   // and one digit right (backspace, zero enters at the MSD).
   logic [4*DIGITS-1:0] w_shl;
   logic [4*DIGITS-1:0] w_shr;

   logic [CW-1:0]       w_load_count;
   logic [CW-1:0]       w_shl_count;
   logic                w_is_numeric;
   logic                w_is_full;
   logic                w_is_empty;

   // Number of significant digits: position of the highest nonzero digit
   // plus one. Digits above 9 count as nonzero, so a bad load value still
   // gets a sensible length.
   function automatic logic [CW-1:0] sig_count(input logic [4*DIGITS-1:0] v);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] != 4'd0) begin
            c = CW'(i + 1);
         end
      end
      return c;
   endfunction

   // ------------------------------------------------------------------------
   // Digit shifters, built per digit so DIGITS=1 needs no special slicing
   // ------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_shift
         if (gi == 0) begin : g_lsd
            assign w_shl[3:0] = digit;
         end else begin : g_upper_l
            assign w_shl[4*gi +: 4] = r_bcd[4*(gi-1) +: 4];
         end

         if (gi == DIGITS - 1) begin : g_msd
            assign w_shr[4*gi +: 4] = 4'd0;
         end else begin : g_lower_r
            assign w_shr[4*gi +: 4] = r_bcd[4*(gi+1) +: 4];
         end
      end
   endgenerate

   assign w_load_count = sig_count(load_value);
   assign w_shl_count  = sig_count(w_shl);
   assign w_is_numeric = (digit <= 4'd9);
   assign w_is_full    = (r_count == MAX_COUNT);
   assign w_is_empty   = (r_count == '0);

   // ------------------------------------------------------------------------
   // Next-state decode. Priority: clear > load > bksp > keystrobe. A
   // lower-priority strobe that arrives in the same cycle is dropped.
   // ------------------------------------------------------------------------
   always_comb begin
      w_bcd_next    = r_bcd;
      w_count_next  = r_count;
      w_reject_next = 1'b0;

      if (clear) begin
         w_bcd_next   = '0;
         w_count_next = '0;
      end else if (load) begin
         w_bcd_next   = load_value;
         w_count_next = w_load_count;
      end else if (bksp) begin
         if (!w_is_empty) begin
            w_bcd_next   = w_shr;
            w_count_next = r_count - CW'(1);
         end
      end else if (keystrobe && w_is_numeric) begin
         if (w_is_empty && (digit == 4'd0)) begin
            // No leading zeros: an empty register keeps showing a single "0".
            w_bcd_next = r_bcd;
         end else if (!w_is_full) begin
            // Digits above count are zero, so a plain left shift is exact.
            w_bcd_next   = w_shl;
            w_count_next = r_count + CW'(1);
         end else if (FULL_MODE == 0) begin
            w_reject_next = 1'b1;
         end else begin
            // Scrolling can expose zeros at the top (e.g. 304 -> 045), so
            // the length is recomputed rather than held at DIGITS.
            w_bcd_next   = w_shl;
            w_count_next = w_shl_count;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_bcd    <= '0;
         r_count  <= '0;
         r_reject <= 1'b0;
      end else begin
         r_bcd    <= w_bcd_next;
         r_count  <= w_count_next;
         r_reject <= w_reject_next;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs. blank and full decode only the registered count.
   // ------------------------------------------------------------------------
   assign bcd    = r_bcd;
   assign count  = r_count;
   assign reject = r_reject;
   assign full   = w_is_full;

   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_blank
         if (gi == 0) begin : g_units
            // The units digit always lights so an empty register shows "0".
            assign blank[0] = 1'b0;
         end else begin : g_upper
            assign blank[gi] = (r_count <= CW'(gi));
         end
      end
   endgenerate

endmodule
